// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer.
// State encoding, key-size round counts and round index width.
package aes_pkg;

   localparam int AES_ROUNDS_128 = 10;
   localparam int AES_ROUNDS_192 = 12;
   localparam int AES_ROUNDS_256 = 14;
   localparam int ROUND_IDX_W    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT_ARK,
      ST_SB,
      ST_SR,
      ST_MC,
      ST_ARK,
      ST_DONE
   } aes_state_e;

   function automatic logic is_ark(input aes_state_e s);
      return (s == ST_INIT_ARK) || (s == ST_ARK);
   endfunction

endpackage

// File: rtl/aes_round_ctrl_round_counter.sv
// Round index register for the AES sequencer.
// Clear has priority; increments saturate at the terminal round.
module aes_round_ctrl_round_counter
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_ROUNDS_128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   inc,
   output logic [ROUND_IDX_W-1:0] idx,
   output logic                   last
);

   localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(NUM_ROUNDS);

   assign last = (idx == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (inc && !last) begin
         idx <= idx + 1'b1;
      end
   end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: one transformation step per clock,
// round index to the key schedule, valid/ready block hand-off.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_ROUNDS_128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   key_ready,
   input  logic                   out_ready,
   output logic                   load_state,
   output logic                   sb_en,
   output logic                   sr_en,
   output logic                   mc_en,
   output logic                   ark_en,
   output logic                   state_we,
   output logic [ROUND_IDX_W-1:0] round_idx,
   output logic                   busy,
   output logic                   out_valid
);

   aes_state_e state_q;
   aes_state_e state_d;

   logic idle_q;
   logic sb_q;
   logic sr_q;
   logic mc_q;
   logic ark_q;
   logic done_q;

   logic cnt_clr;
   logic cnt_inc;
   logic last;

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) state_d = ST_INIT_ARK;
            end
            ST_INIT_ARK: begin
               if (key_ready) state_d = ST_SB;
            end
            ST_SB: begin
               state_d = ST_SR;
            end
            ST_SR: begin
               state_d = last ? ST_ARK : ST_MC;
            end
            ST_MC: begin
               state_d = ST_ARK;
            end
            ST_ARK: begin
               if (key_ready) state_d = last ? ST_DONE : ST_SB;
            end
            ST_DONE: begin
               if (out_ready) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Step flags are decoded from the next state so they leave flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idle_q  <= 1'b1;
         sb_q    <= 1'b0;
         sr_q    <= 1'b0;
         mc_q    <= 1'b0;
         ark_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idle_q  <= (state_d == ST_IDLE);
         sb_q    <= (state_d == ST_SB);
         sr_q    <= (state_d == ST_SR);
         mc_q    <= (state_d == ST_MC);
         ark_q   <= is_ark(state_d);
         done_q  <= (state_d == ST_DONE);
      end
   end

   assign cnt_clr = abort
                  || (state_q == ST_IDLE)
                  || ((state_q == ST_DONE) && out_ready);

   assign cnt_inc = !abort && key_ready && is_ark(state_q)
                  && !((state_q == ST_ARK) && last);

   aes_round_ctrl_round_counter #(
      .NUM_ROUNDS(NUM_ROUNDS)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .idx (round_idx),
      .last(last)
   );

   // Abort kills every enable in its own cycle.
   assign load_state = idle_q && start && !abort && !rst;
   assign sb_en      = sb_q && !abort;
   assign sr_en      = sr_q && !abort;
   assign mc_en      = mc_q && !abort;
   assign ark_en     = ark_q && key_ready && !abort;
   assign state_we   = load_state | sb_en | sr_en | mc_en | ark_en;
   assign busy       = !idle_q;
   assign out_valid  = done_q;

endmodule
